// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, operand width and the
// packed command record carried through the command FIFO.
package alu_pkg;

   localparam int ALU_W = 4;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   typedef struct packed {
      logic [ALU_W-1:0] a;
      logic [ALU_W-1:0] b;
      logic [1:0]       sel;
   } alu_cmd_t;

   localparam alu_cmd_t CMD_ZERO = '{a: 4'h0, b: 4'h0, sel: 2'b00};

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue stage; DEPTH must be a power of two >= 2.
// Occupancy is a DEPTH+1 state counter, pointers wrap modulo DEPTH.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  alu_cmd_t wr_data,
   input  logic     pop,
   output logic     full,
   output logic     empty,
   output alu_cmd_t head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   alu_cmd_t         mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [OCC_W-1:0] occ_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Over/underflow requests are ignored so the pointers can never corrupt.
   assign full      = (occ_r == OCC_FULL);
   assign empty     = (occ_r == {OCC_W{1'b0}});
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign head      = mem_r[rd_ptr_r];

   // Entry storage, written at the write pointer on an accepted push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= CMD_ZERO;
         end
      end else if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         occ_r    <= {OCC_W{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   occ_r <= occ_r + OCC_W'(1);
            2'b01:   occ_r <= occ_r - OCC_W'(1);
            default: occ_r <= occ_r;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage around a combinational 4-bit ALU: command FIFO, response holding
// register with valid/ready, and an optional carry counter (ALU_ISSUE_CNT_EN).
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
`ifdef ALU_ISSUE_CNT_EN
   ,
   parameter int CNT_W = 8
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [ALU_W-1:0] cmd_a,
   input  logic [ALU_W-1:0] cmd_b,
   input  logic [1:0]       cmd_sel,
   output logic [ALU_W-1:0] alu_a,
   output logic [ALU_W-1:0] alu_b,
   output logic [1:0]       alu_sel,
   input  logic [ALU_W-1:0] alu_result,
   input  logic             alu_carry,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [ALU_W-1:0] rsp_result,
   output logic             rsp_carry,
   output logic [1:0]       rsp_sel
`ifdef ALU_ISSUE_CNT_EN
   ,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] carry_cnt
`endif
);

   alu_cmd_t         wr_cmd_s;
   alu_cmd_t         head_s;
   logic             full_s;
   logic             empty_s;
   logic             push_s;
   logic             issue_s;
   logic             rsp_valid_r;
   logic [ALU_W-1:0] rsp_result_r;
   logic             rsp_carry_r;
   logic [1:0]       rsp_sel_r;

   assign wr_cmd_s  = '{a: cmd_a, b: cmd_b, sel: cmd_sel};
   assign cmd_ready = ~full_s;
   assign push_s    = cmd_valid & ~full_s;
   // A held response may be replaced in the same cycle it is drained.
   assign issue_s   = ~empty_s & (~rsp_valid_r | rsp_ready);

   alu_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_s),
      .wr_data (wr_cmd_s),
      .pop     (issue_s),
      .full    (full_s),
      .empty   (empty_s),
      .head    (head_s)
   );

   // Present the FIFO head to the ALU, zero when nothing is queued.
   always_comb begin
      alu_a   = {ALU_W{1'b0}};
      alu_b   = {ALU_W{1'b0}};
      alu_sel = 2'b00;
      if (!empty_s) begin
         alu_a   = head_s.a;
         alu_b   = head_s.b;
         alu_sel = head_s.sel;
      end else begin
         alu_a   = {ALU_W{1'b0}};
         alu_b   = {ALU_W{1'b0}};
         alu_sel = 2'b00;
      end
   end

   // Response holding register with valid/ready handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_r  <= 1'b0;
         rsp_result_r <= {ALU_W{1'b0}};
         rsp_carry_r  <= 1'b0;
         rsp_sel_r    <= 2'b00;
      end else if (issue_s) begin
         rsp_valid_r  <= 1'b1;
         rsp_result_r <= alu_result;
         rsp_carry_r  <= alu_carry;
         rsp_sel_r    <= head_s.sel;
      end else if (rsp_valid_r && rsp_ready) begin
         rsp_valid_r  <= 1'b0;
      end
   end

   assign rsp_valid  = rsp_valid_r;
   assign rsp_result = rsp_result_r;
   assign rsp_carry  = rsp_carry_r;
   assign rsp_sel    = rsp_sel_r;

`ifdef ALU_ISSUE_CNT_EN
   logic [CNT_W-1:0] carry_cnt_r;

   // Saturating count of issued results with carry set; clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_clr) begin
         carry_cnt_r <= {CNT_W{1'b0}};
      end else if (issue_s && alu_carry && (carry_cnt_r != {CNT_W{1'b1}})) begin
         carry_cnt_r <= carry_cnt_r + CNT_W'(1);
      end
   end

   assign carry_cnt = carry_cnt_r;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: queue-based reference model compared
// every cycle, plus directed literal checks and randomized traffic.
module tb_alu_issue_stage;
   import alu_pkg::*;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_a = 4'h0;
   logic [3:0] cmd_b = 4'h0;
   logic [1:0] cmd_sel = 2'b00;
   logic [3:0] alu_a, alu_b;
   logic [1:0] alu_sel;
   logic [3:0] alu_result;
   logic       alu_carry;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [3:0] rsp_result;
   logic       rsp_carry;
   logic [1:0] rsp_sel;
`ifdef ALU_ISSUE_CNT_EN
   logic       cnt_clr = 1'b0;
   logic [7:0] carry_cnt;
   int         m_cnt = 0;
`endif

   int n_pass = 0;
   int n_total = 0;
   int dut_hs = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_sel    (cmd_sel),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_result (alu_result),
      .alu_carry  (alu_carry),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_carry  (rsp_carry),
      .rsp_sel    (rsp_sel)
`ifdef ALU_ISSUE_CNT_EN
      ,
      .cnt_clr    (cnt_clr),
      .carry_cnt  (carry_cnt)
`endif
   );

   // Bench-side ALU: returns {carry, result}; SUB carry means no borrow.
   function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] sel);
      case (sel)
         2'b00:   return {1'b0, a & b};
         2'b01:   return {1'b0, a | b};
         2'b10:   return {1'b0, a} + {1'b0, b};
         default: return {1'b0, a} + {1'b0, ~b} + 5'd1;
      endcase
   endfunction

   assign {alu_carry, alu_result} = alu_fn(alu_a, alu_b, alu_sel);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: pending commands in a queue, one held response.
   logic [9:0] m_q[$];
   logic       m_valid = 1'b0;
   logic [3:0] m_res = 4'h0;
   logic       m_car = 1'b0;
   logic [1:0] m_sel = 2'b00;
   logic [9:0] m_h;
   logic       m_iss, m_psh;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_valid = 1'b0; m_res = 4'h0; m_car = 1'b0; m_sel = 2'b00;
`ifdef ALU_ISSUE_CNT_EN
         m_cnt = 0;
`endif
      end else begin
         m_iss = (m_q.size() > 0) && (!m_valid || rsp_ready);
         m_psh = cmd_valid && (m_q.size() < DEPTH);
`ifdef ALU_ISSUE_CNT_EN
         if (cnt_clr) m_cnt = 0;
         else if (m_iss && alu_fn(m_q[0][9:6], m_q[0][5:2], m_q[0][1:0]) > 5'd15 && m_cnt < 255)
            m_cnt++;
`endif
         if (m_iss) begin
            m_h = m_q.pop_front();
            {m_car, m_res} = alu_fn(m_h[9:6], m_h[5:2], m_h[1:0]);
            m_sel = m_h[1:0];
            m_valid = 1'b1;
         end else if (rsp_ready) begin
            m_valid = 1'b0;
         end
         if (m_psh) m_q.push_back({cmd_a, cmd_b, cmd_sel});
      end
   end

   always @(posedge clk) if (rst_n && rsp_valid && rsp_ready) dut_hs++;

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(m_q.size() < DEPTH));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("rsp_result", 32'(rsp_result), 32'(m_res));
      chk("rsp_carry", 32'(rsp_carry), 32'(m_car));
      chk("rsp_sel", 32'(rsp_sel), 32'(m_sel));
      chk("alu_a", 32'(alu_a), (m_q.size() > 0) ? 32'(m_q[0][9:6]) : 32'd0);
      chk("alu_b", 32'(alu_b), (m_q.size() > 0) ? 32'(m_q[0][5:2]) : 32'd0);
      chk("alu_sel", 32'(alu_sel), (m_q.size() > 0) ? 32'(m_q[0][1:0]) : 32'd0);
`ifdef ALU_ISSUE_CNT_EN
      chk("carry_cnt", 32'(carry_cnt), 32'(m_cnt));
`endif
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic single(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel,
                         input logic [3:0] exp_res, input logic exp_car);
      cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("lat_not_yet_valid", 32'(rsp_valid), 32'd0);
      chk("lat_alu_a", 32'(alu_a), 32'(a));
      tick();
      chk("lit_valid", 32'(rsp_valid), 32'd1);
      chk("lit_result", 32'(rsp_result), 32'(exp_res));
      chk("lit_carry", 32'(rsp_carry), 32'(exp_car));
      chk("lit_sel", 32'(rsp_sel), 32'(sel));
      tick();
      chk("lit_drained", 32'(rsp_valid), 32'd0);
   endtask

   int h0;

   initial begin
      // Reset with a command offered: nothing may be recorded.
      #1 rst_n = 1'b0;
      cmd_valid = 1'b1; cmd_a = 4'h5; cmd_b = 4'h3; rsp_ready = 1'b1;
      repeat (3) tick();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_result", 32'(rsp_result), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      cmd_valid = 1'b0;
      rst_n = 1'b1;
      repeat (2) tick();
      chk("rst_no_push", 32'(rsp_valid), 32'd0);
      chk("rst_no_head", 32'(alu_a), 32'd0);

      // Single operations with literal expectations.
      single(4'b0101, 4'b0011, OP_AND, 4'b0001, 1'b0);
      single(4'b0101, 4'b0011, OP_OR,  4'b0111, 1'b0);
      single(4'b1111, 4'b0001, OP_ADD, 4'b0000, 1'b1);
      single(4'b0101, 4'b0011, OP_SUB, 4'b0010, 1'b1);
      single(4'b0011, 4'b0101, OP_SUB, 4'b1110, 1'b0);

      // Backpressure: five commands, one held plus four queued.
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cmd_a = 4'(i + 1); cmd_b = 4'h2; cmd_sel = OP_ADD;
         tick();
      end
      cmd_valid = 1'b0;
      chk("bp_full", 32'(cmd_ready), 32'd0);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_hold", 32'(rsp_result), 32'd3);
      end
      rsp_ready = 1'b1;
      h0 = dut_hs;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("bp_order", 32'(rsp_result), 32'(k + 4));
      end
      tick();
      chk("bp_empty", 32'(rsp_valid), 32'd0);
      chk("bp_count", 32'(dut_hs - h0), 32'd5);

      // Streaming 16 back-to-back commands.
      h0 = dut_hs;
      cmd_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_sel = 2'($urandom);
         tick();
         if (i >= 1) chk("stream_cont", 32'(rsp_valid), 32'd1);
      end
      cmd_valid = 1'b0;
      repeat (3) tick();
      chk("stream_count", 32'(dut_hs - h0), 32'd16);

      // Mid-stream reset with a held response and three queued entries.
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cmd_a = 4'hF; cmd_b = 4'(i + 1); cmd_sel = OP_OR;
         tick();
      end
      cmd_valid = 1'b0;
      chk("mid_valid", 32'(rsp_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
      chk("mid_rst_result", 32'(rsp_result), 32'd0);
      chk("mid_rst_alu", 32'(alu_a), 32'd0);
      tick();
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mid_no_stale", 32'(rsp_valid), 32'd0);
      end

`ifdef ALU_ISSUE_CNT_EN
      for (int i = 0; i < 3; i++) single(4'hF, 4'h1, OP_ADD, 4'h0, 1'b1);
      chk("cnt_three", 32'(carry_cnt), 32'd3);
      cmd_a = 4'hF; cmd_b = 4'h1; cmd_sel = OP_ADD; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("cnt_clr_prio", 32'(carry_cnt), 32'd0);
      tick();
      cmd_valid = 1'b1;
      for (int i = 0; i < 260; i++) tick();
      cmd_valid = 1'b0;
      repeat (3) tick();
      chk("cnt_saturate", 32'(carry_cnt), 32'hFF);
`endif

      // Randomized traffic checked by the model every cycle.
      for (int i = 0; i < 3000; i++) begin
         cmd_valid = 1'($urandom_range(0, 1));
         rsp_ready = (($urandom % 4) != 0);
         cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_sel = 2'($urandom);
`ifdef ALU_ISSUE_CNT_EN
         cnt_clr = (($urandom % 50) == 0);
`endif
         tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (8) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Command-issue and result-capture stage wrapped around the 4-bit combinational ALU (AND/OR/ADD/SUB). It buffers incoming operand/opcode commands in a small FIFO and presents the head entry to the ALU. It registers the ALU's result and carry into an output holding register with a valid/ready handshake. This lets a sequencer stream operations in at up to one per cycle while the consumer applies backpressure.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- CNT_W, 8, width of the carry-event counter (present only with ALU_ISSUE_CNT_EN)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_a  in  4  operand a
- cmd_b  in  4  operand b
- cmd_sel  in  2  opcode: 00 AND, 01 OR, 10 ADD, 11 SUB
- alu_a  out  4  to ALU a
- alu_b  out  4  to ALU b
- alu_sel  out  2  to ALU sel
- alu_result  in  4  from ALU result; combinational function of alu_a/b/sel
- alu_carry  in  1  from ALU carry_out
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts
- rsp_result  out  4  captured result
- rsp_carry  out  1  captured carry
- rsp_sel  out  2  opcode that produced the response
- cnt_clr  in  1  synchronous clear of carry counter (ALU_ISSUE_CNT_EN only)
- carry_cnt  out  CNT_W  number of responses captured with carry=1 (ALU_ISSUE_CNT_EN only)

## Operation
- Push: cmd_valid && cmd_ready writes {cmd_a, cmd_b, cmd_sel} at the write pointer.
- alu_a/alu_b/alu_sel are driven directly from the FIFO head when non-empty, and are 0 when empty.
- Issue condition: !empty && (!rsp_valid || rsp_ready).
  - On issue, pop the head and load rsp_result ← alu_result, rsp_carry ← alu_carry, rsp_sel ← head sel.
  - Set rsp_valid.
- rsp_valid clears when rsp_ready && rsp_valid and there is no issue that cycle. A drain and a new issue in the same cycle keep rsp_valid=1 with the new data.
- rsp_* are stable while rsp_valid && !rsp_ready.
- Occupancy uses a DEPTH+1-state count, or pointers with an extra wrap bit; pointers wrap modulo DEPTH.
- Full: cmd_ready=0 even if a pop occurs the same cycle; there is no combinational ready path from rsp_ready.
- Empty: a push is not issued in the same cycle; there is no FIFO bypass.
- Simultaneous push and pop when neither full nor empty leaves occupancy unchanged.
- The ALU is treated as purely combinational; this block performs no arithmetic.

## Timing
- Reset (async assert, sync-deasserted externally):
  - FIFO empty
  - cmd_ready=1
  - rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_sel=0
  - alu_a=alu_b=0, alu_sel=0
  - carry_cnt=0
- Latency: a command accepted at edge N is on alu_* during cycle N+1 and captured at edge N+1. rsp_valid is high from cycle N+2.
- Throughput: one command per cycle sustained while rsp_ready=1.
- Reset asserted mid-stream discards all FIFO contents and any held response immediately; no partial response survives.

## Configuration
- ALU_ISSUE_CNT_EN defined:
  - carry_cnt and cnt_clr exist.
  - The counter increments on each issue with alu_carry=1 and saturates at all-ones.
  - cnt_clr has priority over increment.
- ALU_ISSUE_CNT_EN undefined: both ports and the counter logic are absent; all other behaviour is identical.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11
  - operand width constant ALU_W=4
  - packed command typedef alu_cmd_t {a, b, sel}
- One sub-module, alu_cmd_fifo:
  - parameterised DEPTH, storing alu_cmd_t
  - ports push/pop/full/empty/head
- Issue logic, response register and counter live in the top.

## Test plan
- Reset: hold rst_n=0 with cmd_valid=1 → cmd_ready=1, rsp_valid=0, all data outputs 0, no push recorded.
- Single ops with rsp_ready=1, ALU attached:
  - a=0101 b=0011 sel=00 → rsp_result=0001, rsp_valid 2 cycles after accept.
  - sel=01 → 0111.
  - a=1111 b=0001 sel=10 → result 0000, rsp_carry=1.
- Backpressure:
  - rsp_ready=0, push 5 commands → 1 held in response register, 4 in FIFO, cmd_ready=0.
  - rsp_* unchanged for 10 cycles.
  - Release rsp_ready → 5 responses in order, one per cycle.
- Streaming: back-to-back 16 commands with rsp_ready=1 → 16 responses on consecutive cycles, order and rsp_sel preserved, pointer wrap exercised.
- Mid-stream reset: FIFO holding 3 entries and rsp_valid=1, pulse rst_n low → all outputs return to reset values and no stale response appears afterwards.
- With ALU_ISSUE_CNT_EN:
  - 3 ADD overflows → carry_cnt=3.
  - cnt_clr together with an overflow issue → carry_cnt=0.
  - Force 255 overflows → carry_cnt saturates at 8'hFF.
